// File: rtl/spi_tx_byte_feeder.sv
// spi_tx_byte_feeder
// Byte FIFO in front of an SPI master controller. The host pushes bytes with
// i_Wr_En; a small FSM pops the head and hands it to the controller as a
// one-cycle o_TX_DV pulse whenever the controller reports i_TX_Ready.
//
// Handshake: a byte transfers to the controller on the edge after a cycle in
// which the FSM is in IDLE or WAIT_RDY, i_TX_Ready=1 and the FIFO is not
// empty; o_TX_DV is high for exactly the following cycle and o_TX_Byte holds
// that byte until the next transfer. i_TX_Ready is ignored in the cycle
// after a pulse (HOLD) so the controller has time to drop it.
module spi_tx_byte_feeder #(
   parameter int DEPTH = 8
) (
   input  logic                     i_Clk,
   input  logic                     i_Rst_L,
   input  logic [7:0]               i_Wr_Byte,
   input  logic                     i_Wr_En,
   input  logic                     i_Flush,
   output logic                     o_Full,
   output logic                     o_Empty,
   output logic [$clog2(DEPTH):0]   o_Count,
   output logic                     o_Overflow,
   output logic [7:0]               o_TX_Byte,
   output logic                     o_TX_DV,
   input  logic                     i_TX_Ready,
   output logic [1:0]               o_State
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      HOLD     = 2'd1,
      WAIT_RDY = 2'd2
   } state_t;

   state_t          state, state_nxt;
   logic [7:0]      mem [DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [CW-1:0]   count_nxt;
   logic            issue;
   logic            wr_acc;

   // Debug view of the FSM state.
   assign o_State = state;

   // Pop/write qualification; a flush drops any same-cycle write.
   always_comb begin
      issue  = 1'b0;
      wr_acc = 1'b0;
      if ((state == IDLE || state == WAIT_RDY) && i_TX_Ready && !o_Empty) begin
         issue = 1'b1;
      end
      if (i_Wr_En && !o_Full && !i_Flush) begin
         wr_acc = 1'b1;
      end
   end

   // Next occupancy; simultaneous push and pop leave it unchanged.
   always_comb begin
      count_nxt = o_Count;
      case ({wr_acc, issue})
         2'b10:   count_nxt = o_Count + CW'(1);
         2'b01:   count_nxt = o_Count - CW'(1);
         default: count_nxt = o_Count;
      endcase
   end

   // Next-state logic for the issue FSM.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (issue) state_nxt = HOLD;
         end
         HOLD: begin
            state_nxt = WAIT_RDY;
         end
         WAIT_RDY: begin
            if (issue)           state_nxt = HOLD;
            else if (i_TX_Ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // FSM state register.
   always_ff @(posedge i_Clk) begin
      if (!i_Rst_L) state <= IDLE;
      else          state <= state_nxt;
   end

   // Storage array; contents need no reset since the pointers define validity.
   always_ff @(posedge i_Clk) begin
      if (i_Rst_L && wr_acc) mem[wr_ptr] <= i_Wr_Byte;
   end

   // Pointers, occupancy flags and sticky overflow.
   always_ff @(posedge i_Clk) begin
      if (!i_Rst_L) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         o_Count    <= '0;
         o_Full     <= 1'b0;
         o_Empty    <= 1'b1;
         o_Overflow <= 1'b0;
      end else begin
         if (i_Flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            o_Count <= '0;
            o_Full  <= 1'b0;
            o_Empty <= 1'b1;
         end else begin
            if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
            if (issue)  rd_ptr <= rd_ptr + AW'(1);
            o_Count <= count_nxt;
            o_Full  <= (count_nxt == FULL_CNT);
            o_Empty <= (count_nxt == '0);
         end
         if (i_Wr_En && o_Full) o_Overflow <= 1'b1;
      end
   end

   // Controller-facing outputs: head byte and one-cycle valid pulse.
   always_ff @(posedge i_Clk) begin
      if (!i_Rst_L) begin
         o_TX_Byte <= 8'h00;
         o_TX_DV   <= 1'b0;
      end else begin
         o_TX_DV <= issue;
         if (issue) o_TX_Byte <= mem[rd_ptr];
      end
   end

endmodule

// File: tb/tb_spi_tx_byte_feeder.sv
// Bench for spi_tx_byte_feeder: a fill/overflow vector table plus hand
// sequences for latency, ready back-pressure, streaming wraps, flush and
// mid-transfer reset. Bytes expected at the controller sit in exp_q.
module tb_spi_tx_byte_feeder;

   localparam int DEPTH = 8;

   logic       clk = 1'b0;
   logic       rst_l;
   logic [7:0] wr_byte;
   logic       wr_en;
   logic       flush;
   logic       full;
   logic       empty;
   logic [3:0] count;
   logic       overflow;
   logic [7:0] tx_byte;
   logic       tx_dv;
   logic       tx_ready;
   logic [1:0] state;

   int checks = 0;
   int errors = 0;
   int dv_count = 0;
   logic prev_dv = 1'b0;
   logic [7:0] exp_q[$];

   typedef struct {
      logic       wr_en;
      logic [7:0] wr_byte;
      logic [3:0] exp_count;
      logic       exp_full;
      logic       exp_empty;
      logic       exp_ovf;
   } vec_t;

   vec_t vecs[9];

   spi_tx_byte_feeder #(.DEPTH(DEPTH)) dut (
      .i_Clk      (clk),
      .i_Rst_L    (rst_l),
      .i_Wr_Byte  (wr_byte),
      .i_Wr_En    (wr_en),
      .i_Flush    (flush),
      .o_Full     (full),
      .o_Empty    (empty),
      .o_Count    (count),
      .o_Overflow (overflow),
      .o_TX_Byte  (tx_byte),
      .o_TX_DV    (tx_dv),
      .i_TX_Ready (tx_ready),
      .o_State    (state)
   );

   // Clock and watchdog.
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_byte(input logic [7:0] b, input bit expect_out);
      wr_en   = 1'b1;
      wr_byte = b;
      if (expect_out) exp_q.push_back(b);
      tick();
      wr_en = 1'b0;
   endtask

   task automatic wait_drain(input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         tick();
         n++;
      end
      check("drain_timeout", exp_q.size(), 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_tx_byte"}, tx_byte, 8'h00);
      check({tag, "_tx_dv"}, tx_dv, 0);
      check({tag, "_full"}, full, 0);
      check({tag, "_empty"}, empty, 1);
      check({tag, "_count"}, count, 0);
      check({tag, "_overflow"}, overflow, 0);
      check({tag, "_state"}, state, 0);
   endtask

   // Scoreboard monitor: sampled on the falling edge.
   always @(negedge clk) begin
      if (tx_dv === 1'b1) begin
         dv_count++;
         check("dv_not_consecutive", prev_dv, 0);
         if (exp_q.size() == 0) check("dv_unexpected", tx_dv, 0);
         else check("tx_byte_order", tx_byte, exp_q.pop_front());
      end
      prev_dv = tx_dv;
      if (rst_l === 1'b1) begin
         check("full_consistent", full, (count == 4'(DEPTH)));
         check("empty_consistent", empty, (count == 0));
      end
   end

   initial begin
      int d0;
      rst_l    = 1'b0;
      wr_en    = 1'b0;
      wr_byte  = 8'h00;
      flush    = 1'b0;
      tx_ready = 1'b0;

      // Fill/overflow table: bytes 1..8 then a dropped 0xFF, ready held low.
      for (int i = 0; i < 8; i++) begin
         vecs[i] = '{1'b1, 8'(i + 1), 4'(i + 1), (i == 7), 1'b0, 1'b0};
      end
      vecs[8] = '{1'b1, 8'hFF, 4'd8, 1'b1, 1'b0, 1'b1};

      tick();
      tick();
      check_reset_outputs("reset");
      rst_l = 1'b1;
      tick();

      // Latency: write 0xA5 into empty FIFO with ready high.
      tx_ready = 1'b1;
      write_byte(8'hA5, 1'b1);
      check("lat_dv_n", tx_dv, 0);
      check("lat_count_n", count, 1);
      tick();
      check("lat_dv_n1", tx_dv, 1);
      check("lat_byte_n1", tx_byte, 8'hA5);
      check("lat_count_n1", count, 0);
      check("lat_empty_n1", empty, 1);
      tick();
      check("lat_dv_n2", tx_dv, 0);
      check("lat_byte_hold", tx_byte, 8'hA5);
      tick();
      tick();

      // Table-driven fill and overflow.
      tx_ready = 1'b0;
      for (int i = 0; i < 9; i++) begin
         wr_en   = vecs[i].wr_en;
         wr_byte = vecs[i].wr_byte;
         if (i < 8) exp_q.push_back(vecs[i].wr_byte);
         tick();
         check($sformatf("fill%0d_count", i), count, vecs[i].exp_count);
         check($sformatf("fill%0d_full", i), full, vecs[i].exp_full);
         check($sformatf("fill%0d_empty", i), empty, vecs[i].exp_empty);
         check($sformatf("fill%0d_ovf", i), overflow, vecs[i].exp_ovf);
      end
      wr_en    = 1'b0;
      tx_ready = 1'b1;
      wait_drain(100);
      tick();
      check("drain_ovf_sticky", overflow, 1);
      check("drain_count", count, 0);
      check("drain_empty", empty, 1);

      // Reset clears the sticky overflow.
      rst_l = 1'b0;
      tick();
      check("ovf_cleared", overflow, 0);
      rst_l = 1'b1;
      tick();

      // Ready low for 20 cycles after a pulse with 3 bytes still queued.
      tx_ready = 1'b0;
      write_byte(8'h10, 1'b1);
      write_byte(8'h20, 1'b1);
      write_byte(8'h30, 1'b1);
      write_byte(8'h40, 1'b1);
      tx_ready = 1'b1;
      tick();
      tx_ready = 1'b0;
      check("rdy_first_dv", tx_dv, 1);
      check("rdy_first_byte", tx_byte, 8'h10);
      tick();
      d0 = dv_count;
      repeat (20) tick();
      check("rdy_low_no_dv", dv_count - d0, 0);
      check("rdy_low_state", state, 2);
      check("rdy_low_count", count, 3);
      tx_ready = 1'b1;
      tick();
      check("rdy_return_dv", tx_dv, 1);
      check("rdy_return_byte", tx_byte, 8'h20);
      wait_drain(50);

      // Streaming across several pointer wraps.
      for (int i = 0; i < 30; i++) begin
         write_byte(8'($urandom_range(0, 255)), 1'b1);
         check("stream_count_max", (count <= 4'(DEPTH)), 1);
         tick();
      end
      wait_drain(100);
      tick();
      tick();

      // Flush with 5 bytes queued; same-cycle write is dropped.
      tx_ready = 1'b0;
      for (int i = 0; i < 5; i++) write_byte(8'h80 + 8'(i), 1'b0);
      check("flush_pre_count", count, 5);
      flush   = 1'b1;
      wr_en   = 1'b1;
      wr_byte = 8'hEE;
      tick();
      flush = 1'b0;
      wr_en = 1'b0;
      check("flush_count", count, 0);
      check("flush_empty", empty, 1);
      check("flush_full", full, 0);
      d0 = dv_count;
      tx_ready = 1'b1;
      repeat (10) tick();
      check("flush_no_dv", dv_count - d0, 0);

      // Flush and issue in the same cycle: pre-flush head still goes out.
      tx_ready = 1'b0;
      write_byte(8'h5A, 1'b1);
      write_byte(8'h6B, 1'b0);
      d0 = dv_count;
      tx_ready = 1'b1;
      flush    = 1'b1;
      tick();
      flush = 1'b0;
      check("flush_issue_dv", tx_dv, 1);
      check("flush_issue_byte", tx_byte, 8'h5A);
      check("flush_issue_count", count, 0);
      check("flush_issue_empty", empty, 1);
      repeat (10) tick();
      check("flush_issue_one_dv", dv_count - d0, 1);

      // Reset while in WAIT_RDY with 4 bytes queued.
      tx_ready = 1'b0;
      for (int i = 0; i < 5; i++) write_byte(8'hC0 + 8'(i), 1'b1);
      tx_ready = 1'b1;
      tick();
      tx_ready = 1'b0;
      tick();
      tick();
      check("pre_rst_state", state, 2);
      check("pre_rst_count", count, 4);
      rst_l = 1'b0;
      tick();
      check_reset_outputs("mid_rst");
      exp_q.delete();
      rst_l    = 1'b1;
      tx_ready = 1'b1;
      d0 = dv_count;
      repeat (10) tick();
      check("post_rst_no_dv", dv_count - d0, 0);
      write_byte(8'h3C, 1'b1);
      wait_drain(20);
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/spi_tx_byte_feeder.md
SPI_TX_BYTE_FEEDER -- requirements
Module: spi_tx_byte_feeder

Interface
REQ-001 Parameter DEPTH, default 8, FIFO entries; SHALL be a power of two, at least 2.
REQ-002 Port i_Clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 Port i_Rst_L  input  1  reset, synchronous, active-low.
REQ-004 Port i_Wr_Byte  input  8  host byte to queue.
REQ-005 Port i_Wr_En  input  1  host write strobe, one byte per cycle high.
REQ-006 Port i_Flush  input  1  synchronous FIFO clear.
REQ-007 Port o_Full  output  1  FIFO holds DEPTH bytes.
REQ-008 Port o_Empty  output  1  FIFO holds 0 bytes.
REQ-009 Port o_Count  output  $clog2(DEPTH)+1  bytes currently queued.
REQ-010 Port o_Overflow  output  1  sticky: write attempted while full.
REQ-011 Port o_TX_Byte  output  8  byte to SPI controller, drives its i_TX_Byte.
REQ-012 Port o_TX_DV  output  1  one-cycle data-valid pulse, drives controller i_TX_DV.
REQ-013 Port i_TX_Ready  input  1  controller o_TX_Ready.

Function
REQ-014 FIFO SHALL be first-in first-out with wrapping read/write pointers; o_Full, o_Empty, o_Count SHALL be registered and mutually consistent every cycle.
REQ-015 Write SHALL be accepted iff i_Wr_En=1 and o_Full=0 in that cycle, regardless of a same-cycle pop.
REQ-016 Write with i_Wr_En=1 and o_Full=1: byte dropped, o_Overflow set to 1 next cycle, held until reset.
REQ-017 Same-cycle accepted write and pop: o_Count unchanged, both pointers advance.
REQ-018 Pointer wrap from DEPTH-1 to 0 SHALL be seamless; o_Count never exceeds DEPTH nor goes below 0.
REQ-019 States: IDLE, HOLD, WAIT_RDY.
REQ-020 IDLE: if o_Empty=0 and i_TX_Ready=1 -> issue, go HOLD; else stay.
REQ-021 Issue: next edge o_TX_DV<=1, o_TX_Byte<=FIFO head, head popped.
REQ-022 HOLD: o_TX_DV<=0; i_TX_Ready ignored; go WAIT_RDY after exactly one cycle.
REQ-023 WAIT_RDY: i_TX_Ready=0 -> stay; i_TX_Ready=1 and o_Empty=0 -> issue, go HOLD; i_TX_Ready=1 and o_Empty=1 -> IDLE.
REQ-024 o_TX_DV SHALL never be high two consecutive cycles; o_TX_Byte SHALL hold its value between issues.
REQ-025 Latency: byte written at edge N into empty FIFO, state IDLE, i_TX_Ready=1 -> o_TX_DV=1 during cycle N+2.
REQ-026 i_Flush=1: next edge pointers and o_Count to 0, o_Empty=1; same-cycle write dropped; a pulse issued that cycle still completes; FSM and o_Overflow unaffected.
REQ-027 Flush and issue same cycle: issued byte is the pre-flush head; FIFO empty after.

Reset
REQ-028 While i_Rst_L=0 at a rising edge: FIFO empty, pointers 0, state IDLE.
REQ-029 Output reset values: o_TX_Byte=0, o_TX_DV=0, o_Full=0, o_Empty=1, o_Count=0, o_Overflow=0.
REQ-030 Reset mid-transfer (any state) SHALL abort; queued bytes discarded; no o_TX_DV until a new write after reset release.
REQ-031 Reset SHALL take priority over i_Flush, i_Wr_En and i_TX_Ready.

Verification
REQ-032 Write 0xA5 with ready=1 -> o_TX_DV one cycle at N+2, o_TX_Byte=0xA5, o_Count back to 0.
REQ-033 Write 0x01..0x08 (DEPTH=8) with ready=0 -> o_Full=1, o_Count=8; ninth write 0xFF -> o_Overflow=1, then ready pulses emit 0x01..0x08 in order, 0xFF never.
REQ-034 Ready held low 20 cycles after a pulse, 3 bytes queued -> no DV during low; next byte issued on the edge after ready returns to 1.
REQ-035 Continuous write+pop across 3 pointer wraps -> output sequence equals input sequence, no DV in consecutive cycles.
REQ-036 i_Flush with 5 bytes queued -> o_Count=0, o_Empty=1 next cycle, no further DV.
REQ-037 i_Rst_L=0 while in WAIT_RDY with 4 bytes queued -> all outputs at REQ-029 values one edge later, no DV after release.
